// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and helpers for the tdest stream demultiplexer
//
// Purpose: slave-side FSM state encoding, the default beat payload layout
// carried through the register slice, and the destination range check.
// Ports: none (package).
package axis_pkg;

  // Slave-side frame state: between frames, forwarding a frame, or
  // swallowing a frame whose first beat named a non-existent port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } demux_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEL_W  = 2;

  // Default payload of one buffered beat. The demux instantiates the slice
  // with its own widths; this layout is the slice's default type.
  typedef struct packed {
    logic [DEF_SEL_W-1:0]  sel;
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } beat_t;

  // True when dest addresses one of the ports that actually exist.
  function automatic logic dest_valid(input logic [31:0] dest, input int ports);
    return dest < 32'(ports);
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - two-entry register slice with registered upstream ready
//
// Purpose: breaks both the valid/data path and the ready path with one output
// register plus one skid entry, sustaining one beat per cycle.
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   in_valid   upstream beat offered
//   in_data    upstream payload
//   in_ready   registered ready towards upstream
//   out_valid  output register holds a beat
//   out_data   output register payload (held after drain until replaced)
//   out_ready  downstream accepts the output beat
module axis_skid_reg
  import axis_pkg::*;
#(
  parameter type payload_t = beat_t
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     in_valid,
  input  payload_t in_data,
  output logic     in_ready,
  output logic     out_valid,
  output payload_t out_data,
  input  logic     out_ready
);

  logic     skid_valid;
  payload_t skid_data;
  logic     push;
  logic     drain;

  assign push  = in_valid && in_ready;
  assign drain = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      // Ready stays high only while the skid entry is guaranteed free next
      // cycle, so a beat accepted on a registered ready always has a home.
      in_ready <= out_ready || (!skid_valid && (!out_valid || !push));

      if (!out_valid || drain) begin
        if (skid_valid) begin
          // Oldest beat first: the skid entry refills the output register.
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          skid_valid <= push;
          if (push) begin
            skid_data <= in_data;
          end
        end else if (push) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (push) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_dest_demux.sv
// rtl/axis_dest_demux.sv - 1-to-PORTS frame demultiplexer steered by first-beat tdest
//
// Purpose: routes each whole frame from the slave stream to the master port
// named by tdest on its first beat; frames naming a missing port are either
// discarded and counted or steered to the last port.
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   s_axis_*        slave stream (tdata, tdest, tlast, tvalid in; tready out)
//   m_axis_tdata    per-port data, port i at [i*DATA_W +: DATA_W]
//   m_axis_tlast    per-port last
//   m_axis_tvalid   per-port valid, at most one set
//   m_axis_tready   per-port ready
//   frame_active    slave side is inside a frame
//   drop_count      discarded frames, saturating
module axis_dest_demux
  import axis_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int DATA_W       = 32,
  parameter int DEST_W       = 2,
  parameter int DROP_INVALID = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DATA_W-1:0]       s_axis_tdata,
  input  logic [DEST_W-1:0]       s_axis_tdest,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [PORTS*DATA_W-1:0] m_axis_tdata,
  output logic [PORTS-1:0]        m_axis_tlast,
  output logic [PORTS-1:0]        m_axis_tvalid,
  input  logic [PORTS-1:0]        m_axis_tready,
  output logic                    frame_active,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int SEL_W = $clog2(PORTS);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              last;
  } demux_beat_t;

  demux_state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] drop_q;

  logic             s_fire;
  logic             first_ok;
  logic [SEL_W-1:0] first_sel;
  logic             drop_beat;
  logic             drop_inc;
  logic             push_valid;
  demux_beat_t      push_beat;
  demux_beat_t      out_beat;
  logic             out_valid;
  logic             out_ready;

  assign s_fire   = s_axis_tvalid && s_axis_tready;
  assign first_ok = dest_valid(32'(s_axis_tdest), PORTS);
  // Out-of-range destinations fold onto the last port when not discarded.
  assign first_sel = first_ok ? s_axis_tdest[SEL_W-1:0] : SEL_W'(PORTS - 1);

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    drop_beat      = 1'b0;
    drop_inc       = 1'b0;
    push_beat.sel  = sel_q;
    push_beat.data = s_axis_tdata;
    push_beat.last = s_axis_tlast;
    case (state_q)
      IDLE: begin
        push_beat.sel = first_sel;
        drop_beat     = !first_ok && (DROP_INVALID != 0);
        if (s_fire) begin
          sel_d    = first_sel;
          drop_inc = drop_beat;
          if (s_axis_tlast) begin
            state_d = IDLE;
          end else begin
            state_d = drop_beat ? DROP : ROUTE;
          end
        end
      end
      ROUTE: begin
        if (s_fire && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        drop_beat = 1'b1;
        if (s_fire && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Discarded beats are still accepted upstream but never reach the slice.
  assign push_valid = s_axis_tvalid && !drop_beat;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (drop_inc && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  axis_skid_reg #(
    .payload_t (demux_beat_t)
  ) u_slice (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (push_valid),
    .in_data   (push_beat),
    .in_ready  (s_axis_tready),
    .out_valid (out_valid),
    .out_data  (out_beat),
    .out_ready (out_ready)
  );

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign m_axis_tvalid[i]                  = out_valid && (out_beat.sel == SEL_W'(i));
    assign m_axis_tlast[i]                   = out_beat.last && (out_beat.sel == SEL_W'(i));
    assign m_axis_tdata[i*DATA_W +: DATA_W] = out_beat.data;
  end

  // Only the addressed port's ready matters; gating by valid also avoids
  // indexing with a sel that names no port.
  assign out_ready = |(m_axis_tvalid & m_axis_tready);

  assign frame_active = (state_q != IDLE);
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_axis_dest_demux.sv
// tb/tb_axis_dest_demux.sv - randomized frame-level scoreboard bench for the tdest demux
module tb_axis_dest_demux;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [31:0]  s_tdata;
  logic [2:0]   s_tdest;
  logic         s_tlast;
  logic         s_tvalid;
  wire          s_tready;
  wire  [127:0] m_tdata;
  wire  [3:0]   m_tlast;
  wire  [3:0]   m_tvalid;
  logic [3:0]   m_tready;
  wire          frame_active;
  wire  [3:0]   drop_count;

  wire          b_s_tready;
  wire  [127:0] b_m_tdata;
  wire  [3:0]   b_m_tlast;
  wire  [3:0]   b_m_tvalid;
  logic [3:0]   b_m_tready = 4'hF;
  wire          b_frame_active;
  wire  [3:0]   b_drop_count;

  always #5 clk = ~clk;

  axis_dest_demux #(
    .PORTS(4), .DATA_W(32), .DEST_W(3), .DROP_INVALID(1), .CNT_W(4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tdest  (s_tdest),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .frame_active  (frame_active),
    .drop_count    (drop_count)
  );

  axis_dest_demux #(
    .PORTS(4), .DATA_W(32), .DEST_W(3), .DROP_INVALID(0), .CNT_W(4)
  ) dut_fold (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tdest  (s_tdest),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (b_s_tready),
    .m_axis_tdata  (b_m_tdata),
    .m_axis_tlast  (b_m_tlast),
    .m_axis_tvalid (b_m_tvalid),
    .m_axis_tready (b_m_tready),
    .frame_active  (b_frame_active),
    .drop_count    (b_drop_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected delivery order of every routed beat, plus
  // frame-level slave state derived from the frame rules.
  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        q[$];
  bit          in_frame = 0;
  bit          dropping = 0;
  logic [1:0]  cur_port = '0;
  int          exp_drop = 0;

  bit          hold = 0;
  logic [3:0]  hold_v;
  logic [127:0] hold_d;
  logic [3:0]  hold_l;

  int cyc = 0;
  int port_beats[4];
  int port_lasts[4];
  int first_s, first_m, last_m, stalls, s_acc, stall_acc;
  bit b_win = 0;
  int b_beats3, b_last3, b_other;

  always @(negedge clk) begin
    int   p;
    exp_t e;
    cyc++;
    if (!rstn) begin
      q.delete();
      in_frame = 0;
      dropping = 0;
      exp_drop = 0;
      hold     = 0;
    end else begin
      check($countones(m_tvalid) <= 1, "tvalid_onehot0", m_tvalid, 0);
      check(frame_active == in_frame, "frame_active", frame_active, in_frame);
      check(drop_count == 4'(exp_drop), "drop_count", drop_count, exp_drop);
      if (hold) begin
        check(m_tvalid == hold_v, "hold_tvalid", m_tvalid, hold_v);
        check(m_tdata == hold_d, "hold_tdata", m_tdata[63:0], hold_d[63:0]);
        check(m_tlast == hold_l, "hold_tlast", m_tlast, hold_l);
      end
      if (m_tvalid != 0) begin
        p = 0;
        for (int i = 3; i >= 0; i--) if (m_tvalid[i]) p = i;
        if (q.size() == 0) begin
          check(1'b0, "spurious_tvalid", m_tvalid, 0);
        end else begin
          check(p == int'(q[0].port), "beat_port", p, q[0].port);
          check(m_tdata[p*32 +: 32] == q[0].data, "beat_data", m_tdata[p*32 +: 32], q[0].data);
          check(m_tlast[p] == q[0].last, "beat_last", m_tlast[p], q[0].last);
          if (m_tready[p]) begin
            port_beats[p]++;
            if (q[0].last) port_lasts[p]++;
            if (first_m < 0) first_m = cyc;
            last_m = cyc;
            void'(q.pop_front());
          end
        end
      end
      hold   = (m_tvalid != 0) && ((m_tvalid & m_tready) == 0);
      hold_v = m_tvalid;
      hold_d = m_tdata;
      hold_l = m_tlast;

      if (s_tvalid && !s_tready) begin
        stalls++;
        if (stall_acc < 0) stall_acc = s_acc;
      end
      if (s_tvalid && s_tready) begin
        if (first_s < 0) first_s = cyc;
        s_acc++;
        if (!in_frame) begin
          dropping = (s_tdest >= 3'd4);
          cur_port = s_tdest[1:0];
          if (dropping && exp_drop < 15) exp_drop++;
        end
        if (!dropping) begin
          e.port = cur_port;
          e.data = s_tdata;
          e.last = s_tlast;
          q.push_back(e);
        end
        in_frame = !s_tlast;
      end

      if (b_win) begin
        if (b_m_tvalid[3]) begin
          b_beats3++;
          if (b_m_tlast[3]) b_last3++;
        end
        if (b_m_tvalid[2:0] != 0) b_other++;
      end
    end
  end

  bit rand_ready = 0;
  int stall_left = 0;

  task automatic tick(output bit rdy);
    @(posedge clk);
    rdy = s_tready;
    #1;
    if (rand_ready) begin
      for (int i = 0; i < 4; i++) m_tready[i] = ($urandom_range(0, 3) != 0);
    end else if (stall_left > 0) begin
      stall_left--;
      m_tready = (stall_left > 0) ? 4'b1011 : 4'b1111;
    end
  endtask

  task automatic idle(input int n);
    bit r;
    s_tvalid = 1'b0;
    repeat (n) tick(r);
  endtask

  task automatic beat(input logic [31:0] d, input logic [2:0] dst, input logic l);
    bit ok;
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tdest  = dst;
    s_tlast  = l;
    n = 0;
    do begin
      tick(ok);
      n++;
    end while (!ok && n < 1000);
    if (!ok) check(1'b0, "beat_accept_timeout", n, 1000);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    bit r;
    int n;
    s_tvalid = 1'b0;
    n = 0;
    while ((q.size() != 0 || m_tvalid != 0) && n < 2000) begin
      tick(r);
      n++;
    end
    tick(r);
    check(n < 2000, "drain_timeout", n, 2000);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      port_beats[i] = 0;
      port_lasts[i] = 0;
    end
    first_s = -1; first_m = -1; last_m = -1;
    stalls = 0; s_acc = 0; stall_acc = -1;
    b_beats3 = 0; b_last3 = 0; b_other = 0;
  endtask

  initial begin
    bit r;
    int len;
    logic [2:0] dst;
    s_tvalid = 1'b0; s_tdata = '0; s_tdest = '0; s_tlast = 1'b0;
    m_tready = 4'hF;
    clear_stats();
    rstn = 1'b0;
    repeat (3) tick(r);
    rstn = 1'b1;
    tick(r);

    // Back-to-back 3-beat frames to every port, no backpressure.
    clear_stats();
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 3; b++)
        beat(32'hA000_0000 | (f << 8) | b, 3'(f), (b == 2));
    drain();
    for (int i = 0; i < 4; i++) begin
      check(port_beats[i] == 3, "t2_port_beats", port_beats[i], 3);
      check(port_lasts[i] == 1, "t2_port_lasts", port_lasts[i], 1);
    end
    check(first_m - first_s == 1, "t2_latency", first_m - first_s, 1);
    check(last_m - first_s == 12, "t2_12_beats_13_cycles", last_m - first_s, 12);
    check(stalls == 0, "t2_no_stall", stalls, 0);

    // tdest changes mid-frame are ignored.
    clear_stats();
    beat(32'hB000_0001, 3'd1, 1'b0);
    beat(32'hB000_0002, 3'd3, 1'b0);
    beat(32'hB000_0003, 3'd3, 1'b1);
    drain();
    check(port_beats[1] == 3, "t3_port1_beats", port_beats[1], 3);
    check(port_beats[3] == 0, "t3_port3_beats", port_beats[3], 0);

    // Out-of-range destination: dropped here, folded to port 3 on dut_fold.
    clear_stats();
    b_win = 1;
    for (int b = 0; b < 4; b++) beat(32'hC000_0000 | b, 3'd5, (b == 3));
    drain();
    b_win = 0;
    check(port_beats[0] + port_beats[1] + port_beats[2] + port_beats[3] == 0,
          "t4_no_delivery", port_beats[0] + port_beats[1] + port_beats[2] + port_beats[3], 0);
    check(drop_count == 4'd1, "t4_drop_count", drop_count, 1);
    check(stalls == 0, "t4_ready_held", stalls, 0);
    check(b_beats3 == 4, "t4_fold_port3_beats", b_beats3, 4);
    check(b_last3 == 1, "t4_fold_port3_last", b_last3, 1);
    check(b_other == 0, "t4_fold_other_ports", b_other, 0);
    check(b_drop_count == 4'd0, "t4_fold_drop_count", b_drop_count, 0);

    // Port 2 stalled for 5 cycles at the start of a 6-beat frame.
    clear_stats();
    m_tready   = 4'b1011;
    stall_left = 5;
    for (int b = 0; b < 6; b++) beat(32'hD000_0000 | b, 3'd2, (b == 5));
    drain();
    check(stall_acc == 2, "t5_ready_falls_after_2", stall_acc, 2);
    check(port_beats[2] == 6, "t5_port2_beats", port_beats[2], 6);
    check(port_lasts[2] == 1, "t5_port2_last", port_lasts[2], 1);

    // Reset in the middle of a partially buffered frame.
    m_tready = 4'h0;
    s_tvalid = 1'b1; s_tdata = 32'hE000_0000; s_tdest = 3'd1; s_tlast = 1'b0;
    tick(r);
    tick(r);
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(r);
      check(s_tready == 1'b0, "t1_rst_tready", s_tready, 0);
      check(m_tvalid == 4'h0, "t1_rst_tvalid", m_tvalid, 0);
      check(m_tlast == 4'h0, "t1_rst_tlast", m_tlast, 0);
      check(m_tdata == '0, "t1_rst_tdata", m_tdata[63:0], 0);
      check(frame_active == 1'b0, "t1_rst_frame_active", frame_active, 0);
      check(drop_count == 4'd0, "t1_rst_drop_count", drop_count, 0);
    end
    clear_stats();
    rstn = 1'b1;
    m_tready = 4'hF;
    check(s_tready == 1'b0, "t1_tready_low_at_release", s_tready, 0);
    tick(r);
    check(s_tready == 1'b1, "t1_tready_rises", s_tready, 1);
    beat(32'hE000_0001, 3'd1, 1'b0);
    beat(32'hE000_0002, 3'd1, 1'b1);
    drain();
    check(port_beats[1] == 2, "t1_resync_beats", port_beats[1], 2);

    // Random traffic: valid gaps, per-port random ready, random dest.
    clear_stats();
    rand_ready = 1;
    for (int f = 0; f < 10000; f++) begin
      len = $urandom_range(1, 4);
      dst = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        beat($urandom, (b == 0) ? dst : 3'($urandom), (b == len - 1));
      end
    end
    rand_ready = 0;
    m_tready = 4'hF;
    drain();
    check(q.size() == 0, "t6_all_delivered", q.size(), 0);
    check(drop_count == 4'hF, "t6_drop_saturated", drop_count, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
